free_list: RTL



---
 rtl/qu_pkg.sv | 10 +
 rtl/free_list.sv | 126 ++++++++++++
 2 files changed

// File: rtl/qu_pkg.sv
// Shared rename-stage geometry for the Qu free list and busy table.
package qu_pkg;

    localparam int DEFAULT_PHY_RF_DEPTH  = 128;
    localparam int DEFAULT_ARCH_RF_DEPTH = 32;
    localparam int PHY_TAG_W             = $clog2(DEFAULT_PHY_RF_DEPTH);

    typedef logic [PHY_TAG_W-1:0] phys_tag_t;

endpackage

// File: rtl/free_list.sv
// Circular FIFO of unallocated physical register tags: two pops and two pushes per cycle.
// Optional speculative-rewind support is enabled by defining QU_FREE_LIST_FLUSH_EN.
module free_list
    import qu_pkg::*;
#(
    parameter int PHY_RF_DEPTH  = DEFAULT_PHY_RF_DEPTH,
    parameter int ARCH_RF_DEPTH = DEFAULT_ARCH_RF_DEPTH,
    localparam int TAG_W        = $clog2(PHY_RF_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef QU_FREE_LIST_FLUSH_EN
    input  logic             flush,
    input  logic [1:0]       commit_cnt,
`endif
    input  logic             alloc1_en,
    output logic             alloc1_valid,
    output logic [TAG_W-1:0] alloc1_tag,
    input  logic             alloc2_en,
    output logic             alloc2_valid,
    output logic [TAG_W-1:0] alloc2_tag,
    input  logic             rel1_en,
    input  logic [TAG_W-1:0] rel1_tag,
    input  logic             rel2_en,
    input  logic [TAG_W-1:0] rel2_tag,
    output logic [TAG_W:0]   free_cnt,
    output logic             overflow_err
);

    localparam int PTR_W         = TAG_W + 1;
    localparam int FREE_AT_RESET = PHY_RF_DEPTH - ARCH_RF_DEPTH;
    localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(PHY_RF_DEPTH);

    logic [TAG_W-1:0] entry_q [PHY_RF_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic             overflow_q, overflow_d;

    logic [TAG_W-1:0] head_idx, head_nxt_idx, tail_idx, tail_nxt_idx;
    logic             alloc_block;
    logic             pop1, pop2;
    logic [1:0]       pop_cnt;
    logic             rel1_ok, rel2_ok, push1, push2;

    // Wrap bits make tail - head the occupancy, even when the list is completely full.
    assign free_cnt     = tail_q - head_q;
    assign overflow_err = overflow_q;

    assign head_idx     = head_q[TAG_W-1:0];
    assign head_nxt_idx = head_idx + TAG_W'(1);
    assign tail_idx     = tail_q[TAG_W-1:0];
    assign tail_nxt_idx = tail_idx + TAG_W'(push1);

    assign alloc1_valid = (free_cnt != '0);
    assign alloc2_valid = (free_cnt > PTR_W'(alloc1_en));
    assign alloc1_tag   = entry_q[head_idx];
    assign alloc2_tag   = alloc1_en ? entry_q[head_nxt_idx] : entry_q[head_idx];

`ifdef QU_FREE_LIST_FLUSH_EN
    assign alloc_block = flush;
`else
    assign alloc_block = 1'b0;
`endif

    assign pop1    = alloc1_en & alloc1_valid & ~alloc_block;
    assign pop2    = alloc2_en & alloc2_valid & ~alloc_block;
    assign pop_cnt = {1'b0, pop1} + {1'b0, pop2};

    // x0 is never renamed, so a release of tag 0 is silently ignored.
    assign rel1_ok = rel1_en && (rel1_tag != '0);
    assign rel2_ok = rel2_en && (rel2_tag != '0);
    assign push1   = rel1_ok && (free_cnt != FULL_CNT);
    assign push2   = rel2_ok && ((free_cnt + PTR_W'(push1)) != FULL_CNT);

    assign tail_d     = tail_q + PTR_W'(push1) + PTR_W'(push2);
    assign overflow_d = overflow_q | (rel1_ok & ~push1) | (rel2_ok & ~push2);

`ifdef QU_FREE_LIST_FLUSH_EN
    logic [PTR_W-1:0] commit_head_q, commit_head_d;

    // NOTE: every variable written in always_comb gets a value on every path first, so no latch is inferred.
    always_comb begin
        commit_head_d = commit_head_q + PTR_W'(commit_cnt);
        head_d        = head_q + PTR_W'(pop_cnt);
        if (flush) begin
            head_d = commit_head_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_head_q <= '0;
        end else begin
            commit_head_q <= commit_head_d;
        end
    end
`else
    assign head_d = head_q + PTR_W'(pop_cnt);
`endif

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= PTR_W'(FREE_AT_RESET);
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array is reset on purpose, because it must hold the initial free tags after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHY_RF_DEPTH; i++) begin
                entry_q[i] <= (i < FREE_AT_RESET) ? TAG_W'(ARCH_RF_DEPTH + i) : '0;
            end
        end else begin
            if (push1) entry_q[tail_idx]     <= rel1_tag;
            if (push2) entry_q[tail_nxt_idx] <= rel2_tag;
        end
    end

endmodule
